// File: rtl/prod_accumulator.sv
// Saturating multiply-accumulate back end: sums a valid/ready stream of 6-bit products
// into groups terminated by in_last, then presents sum/count/overflow on a held handshake.
module prod_accumulator #(
    parameter int ACC_W = 10,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       p_in,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Result is {clipped, value}; the carry out of the widened adder flags saturation.
    function automatic logic [ACC_W:0] sat_add_sum(input logic [ACC_W-1:0] a,
                                                   input logic [5:0]       b);
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + {{(ACC_W-5){1'b0}}, b};
        if (wide[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end else begin
            return wide;
        end
    endfunction

    function automatic logic [CNT_W:0] sat_inc_count(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] wide;
        wide = {1'b0, c} + {{CNT_W{1'b0}}, 1'b1};
        if (wide[CNT_W]) begin
            return {1'b1, {CNT_W{1'b1}}};
        end else begin
            return wide;
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ACC_W-1:0]   sum_r;
    logic [ACC_W-1:0]   sum_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               out_valid_nxt_s;
    logic [ACC_W-1:0]   out_sum_r;
    logic [ACC_W-1:0]   out_sum_nxt_s;
    logic [CNT_W-1:0]   out_count_r;
    logic [CNT_W-1:0]   out_count_nxt_s;
    logic               out_ovf_r;
    logic               out_ovf_nxt_s;
    logic [ACC_W:0]     sum_step_s;
    logic [CNT_W:0]     count_step_s;
    logic               ovf_grp_s;

    // Next-state, accumulator update and result capture.
    always_comb begin
        state_nxt_s     = state_r;
        sum_nxt_s       = sum_r;
        count_nxt_s     = count_r;
        ovf_nxt_s       = ovf_r;
        out_valid_nxt_s = out_valid_r;
        out_sum_nxt_s   = out_sum_r;
        out_count_nxt_s = out_count_r;
        out_ovf_nxt_s   = out_ovf_r;
        sum_step_s      = sat_add_sum(sum_r, p_in);
        count_step_s    = sat_inc_count(count_r);
        ovf_grp_s       = ovf_r | sum_step_s[ACC_W] | count_step_s[CNT_W];

        case (state_r)
            ST_ACC: begin
                if (in_valid) begin
                    if (in_last) begin
                        // Finished group goes straight to the outputs; accumulator restarts clean.
                        out_sum_nxt_s   = sum_step_s[ACC_W-1:0];
                        out_count_nxt_s = count_step_s[CNT_W-1:0];
                        out_ovf_nxt_s   = ovf_grp_s;
                        out_valid_nxt_s = 1'b1;
                        sum_nxt_s       = {ACC_W{1'b0}};
                        count_nxt_s     = {CNT_W{1'b0}};
                        ovf_nxt_s       = 1'b0;
                        state_nxt_s     = ST_HOLD;
                    end else begin
                        sum_nxt_s   = sum_step_s[ACC_W-1:0];
                        count_nxt_s = count_step_s[CNT_W-1:0];
                        ovf_nxt_s   = ovf_grp_s;
                    end
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_ACC;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s     = ST_ACC;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_ACC;
            sum_r       <= {ACC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= {ACC_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
            out_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sum_r       <= sum_nxt_s;
            count_r     <= count_nxt_s;
            ovf_r       <= ovf_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_ACC);
            out_valid_r <= out_valid_nxt_s;
            out_sum_r   <= out_sum_nxt_s;
            out_count_r <= out_count_nxt_s;
            out_ovf_r   <= out_ovf_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_count = out_count_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench: three parameterisations share one stimulus stream, so each test can
// check the default, narrow-sum (ACC_W=8) and narrow-count (CNT_W=2) behaviour at once.
module tb_prod_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] p_in;
    logic       in_last;
    logic       out_ready;

    logic       rdy_a, vld_a, ovf_a;
    logic [9:0] sum_a;
    logic [4:0] cnt_a;
    logic       rdy_b, vld_b, ovf_b;
    logic [7:0] sum_b;
    logic [4:0] cnt_b;
    logic       rdy_c, vld_c, ovf_c;
    logic [9:0] sum_c;
    logic [1:0] cnt_c;

    int n_vec;
    int n_err;

    prod_accumulator #(.ACC_W(10), .CNT_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .p_in(p_in),
        .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready), .out_sum(sum_a),
        .out_count(cnt_a), .out_ovf(ovf_a)
    );
    prod_accumulator #(.ACC_W(8), .CNT_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .p_in(p_in),
        .in_last(in_last), .out_valid(vld_b), .out_ready(out_ready), .out_sum(sum_b),
        .out_count(cnt_b), .out_ovf(ovf_b)
    );
    prod_accumulator #(.ACC_W(10), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .p_in(p_in),
        .in_last(in_last), .out_valid(vld_c), .out_ready(out_ready), .out_sum(sum_c),
        .out_count(cnt_c), .out_ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [5:0] p, input logic last);
        in_valid = 1'b1;
        p_in     = p;
        in_last  = last;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset held two cycles with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_last   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            p_in      = 6'($urandom_range(0, 63));
            tick();
        end
        chk("rst out_valid", {31'd0, vld_a}, 32'd0);
        chk("rst out_sum", {22'd0, sum_a}, 32'd0);
        chk("rst out_count", {27'd0, cnt_a}, 32'd0);
        chk("rst out_ovf", {31'd0, ovf_a}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b1; p_in = 6'd33; out_ready = 1'b1;
        tick();
        chk("post-rst in_ready", {31'd0, rdy_a}, 32'd1);
        chk("idle last ignored", {31'd0, vld_a}, 32'd0);

        // Dot product 6 + 49 + 0 + 12 = 67.
        beat(6'd6, 1'b0);
        chk("dot mid out_valid", {31'd0, vld_a}, 32'd0);
        beat(6'd49, 1'b0);
        beat(6'd0, 1'b0);
        beat(6'd12, 1'b1);
        chk("dot out_valid", {31'd0, vld_a}, 32'd1);
        chk("dot out_sum", {22'd0, sum_a}, 32'd67);
        chk("dot out_count", {27'd0, cnt_a}, 32'd4);
        chk("dot out_ovf", {31'd0, ovf_a}, 32'd0);
        chk("dot hold in_ready", {31'd0, rdy_a}, 32'd0);

        // Next group's first beat offered during HOLD, taken on the following cycle.
        beat(6'd49, 1'b0);
        chk("dot valid one cycle", {31'd0, vld_a}, 32'd0);
        chk("dot in_ready back", {31'd0, rdy_a}, 32'd1);
        for (int i = 0; i < 6; i++) beat(6'd49, (i == 5));
        chk("sat8 out_valid", {31'd0, vld_b}, 32'd1);
        chk("sat8 out_sum", {24'd0, sum_b}, 32'd255);
        chk("sat8 out_count", {27'd0, cnt_b}, 32'd6);
        chk("sat8 out_ovf", {31'd0, ovf_b}, 32'd1);
        chk("sat10 out_sum", {22'd0, sum_a}, 32'd294);
        chk("sat10 out_ovf", {31'd0, ovf_a}, 32'd0);

        // Single-beat group after a saturated one: ovf must not carry over.
        beat(6'd5, 1'b1);
        chk("single hold exit", {31'd0, vld_b}, 32'd0);
        beat(6'd5, 1'b1);
        chk("single out_valid", {31'd0, vld_b}, 32'd1);
        chk("single out_sum", {24'd0, sum_b}, 32'd5);
        chk("single out_count", {27'd0, cnt_b}, 32'd1);
        chk("single out_ovf", {31'd0, ovf_b}, 32'd0);

        // Back-pressure: result 1+2+3 held while upstream offers 9.
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        beat(6'd1, 1'b0);
        beat(6'd2, 1'b0);
        beat(6'd3, 1'b1);
        chk("bp out_valid", {31'd0, vld_a}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            beat(6'd9, 1'b0);
            chk("bp stall out_valid", {31'd0, vld_a}, 32'd1);
            chk("bp stall out_sum", {22'd0, sum_a}, 32'd6);
            chk("bp stall in_ready", {31'd0, rdy_a}, 32'd0);
        end
        out_ready = 1'b1;
        beat(6'd9, 1'b0);
        chk("bp release out_valid", {31'd0, vld_a}, 32'd0);
        chk("bp release in_ready", {31'd0, rdy_a}, 32'd1);
        beat(6'd9, 1'b0);
        beat(6'd1, 1'b1);
        chk("bp next out_sum", {22'd0, sum_a}, 32'd10);
        chk("bp next out_count", {27'd0, cnt_a}, 32'd2);

        // Count saturation: five beats of 1.
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) beat(6'd1, (i == 4));
        chk("cnt2 out_count", {30'd0, cnt_c}, 32'd3);
        chk("cnt2 out_sum", {22'd0, sum_c}, 32'd5);
        chk("cnt2 out_ovf", {31'd0, ovf_c}, 32'd1);
        chk("cnt5 out_count", {27'd0, cnt_a}, 32'd5);
        chk("cnt5 out_ovf", {31'd0, ovf_a}, 32'd0);

        // Reset mid-group discards 10 + 20.
        in_valid = 1'b0;
        tick();
        beat(6'd10, 1'b0);
        beat(6'd20, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst out_valid", {31'd0, vld_a}, 32'd0);
        chk("midrst in_ready", {31'd0, rdy_a}, 32'd1);
        out_ready = 1'b0;
        beat(6'd7, 1'b1);
        chk("midrst out_valid", {31'd0, vld_a}, 32'd1);
        chk("midrst out_sum", {22'd0, sum_a}, 32'd7);
        chk("midrst out_count", {27'd0, cnt_a}, 32'd1);

        // Reset during HOLD drops the pending result.
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("holdrst out_valid", {31'd0, vld_a}, 32'd0);
        chk("holdrst out_sum", {22'd0, sum_a}, 32'd0);
        chk("holdrst in_ready", {31'd0, rdy_a}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
